button_event_capture: RTL and testbench

BUTTON_EVENT_CAPTURE -- requirements
Module: button_event_capture

---
 rtl/button_event_capture.sv | 88 ++++++++
 tb/tb_button_event_capture.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_capture.sv
// Debounced button capture: per-input two-flop synchronizer, consecutive-cycle
// debounce counter, and sticky press/release/overflow flags cleared by a masked ack.
module button_event_capture #(
  parameter int unsigned NUM_INPUTS      = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clock_100mhz,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] stable_level,
  output logic [NUM_INPUTS-1:0] press_pending,
  output logic [NUM_INPUTS-1:0] release_pending,
  output logic [NUM_INPUTS-1:0] overflow,
  output logic                  event_valid,
  input  logic                  ack,
  input  logic [NUM_INPUTS-1:0] ack_mask
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_INPUTS-1:0] sync1;
  logic [NUM_INPUTS-1:0] sync2;
  logic [CNT_W-1:0]      count [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] differ;
  logic [NUM_INPUTS-1:0] done;
  logic [NUM_INPUTS-1:0] press_evt;
  logic [NUM_INPUTS-1:0] release_evt;
  logic [NUM_INPUTS-1:0] clear;

  // A bit completes debouncing when it has disagreed with stable for the full window.
  always_comb begin
    differ      = sync2 ^ stable_level;
    done        = '0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      done[i] = differ[i] && (count[i] == CNT_LAST);
    end
    press_evt   = done & sync2;
    release_evt = done & ~sync2;
    clear       = ack ? ack_mask : '0;
  end

  // Metastability guard: raw_in is sampled here and nowhere else.
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Counter restarts whenever the synchronized level agrees with stable again.
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        if (!differ[i] || done[i]) begin
          count[i] <= '0;
        end else begin
          count[i] <= count[i] + CNT_W'(1);
        end
      end
    end
  end

  // Set wins over clear; overflow only on a repeat press that is not being acked.
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      stable_level    <= '0;
      press_pending   <= '0;
      release_pending <= '0;
      overflow        <= '0;
    end else begin
      stable_level    <= stable_level ^ done;
      press_pending   <= press_evt | (press_pending & ~clear);
      release_pending <= release_evt | (release_pending & ~clear);
      overflow        <= (press_evt & press_pending & ~clear) | (overflow & ~clear);
    end
  end

  assign event_valid = |(press_pending | release_pending);

endmodule

// File: tb/tb_button_event_capture.sv
// Scoreboard bench for button_event_capture: a window-based reference model
// predicts each cycle's outputs, a negedge monitor compares them against the DUT.
module tb_button_event_capture;

  localparam int N = 5;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] raw_in;
  logic [N-1:0] stable_level;
  logic [N-1:0] press_pending;
  logic [N-1:0] release_pending;
  logic [N-1:0] overflow;
  logic         event_valid;
  logic         ack;
  logic [N-1:0] ack_mask;

  button_event_capture #(
    .NUM_INPUTS     (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock_100mhz   (clk),
    .reset          (reset),
    .raw_in         (raw_in),
    .stable_level   (stable_level),
    .press_pending  (press_pending),
    .release_pending(release_pending),
    .overflow       (overflow),
    .event_valid    (event_valid),
    .ack            (ack),
    .ack_mask       (ack_mask)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0]      m_stable, m_pp, m_rp, m_ov;
  int                m_last [N];
  int                m_n;
  logic [N-1:0]      hist [$];
  logic [4*N:0]      exp_q [$];
  int                n_cmp = 0;
  int                n_err = 0;
  int                cyc = 0;

  task automatic model_reset();
    m_stable = '0; m_pp = '0; m_rp = '0; m_ov = '0;
    m_n = 0;
    hist.delete();
    for (int i = 0; i < N; i++) m_last[i] = 0;
  endtask

  // Synchronized level seen just before edge j: the raw level sampled two edges earlier.
  function automatic logic sync_before(int j, int i);
    if (j < 3) return 1'b0;
    return hist[j-3][i];
  endfunction

  // One clock edge: stable flips once D consecutive synchronized samples disagree with it.
  task automatic model_edge();
    logic [N-1:0] ns, npp, nrp, nov;
    logic flip, clr;
    m_n++;
    hist.push_back(raw_in);
    ns = m_stable; npp = m_pp; nrp = m_rp; nov = m_ov;
    for (int i = 0; i < N; i++) begin
      flip = 1'b0;
      if (m_n - m_last[i] >= D) begin
        flip = 1'b1;
        for (int j = m_n - D + 1; j <= m_n; j++)
          if (sync_before(j, i) == m_stable[i]) flip = 1'b0;
      end
      clr = ack && ack_mask[i];
      if (clr) begin npp[i] = 1'b0; nrp[i] = 1'b0; nov[i] = 1'b0; end
      if (flip) begin
        m_last[i] = m_n;
        ns[i] = ~m_stable[i];
        if (ns[i]) begin
          if (m_pp[i] && !clr) nov[i] = 1'b1;
          npp[i] = 1'b1;
        end else begin
          nrp[i] = 1'b1;
        end
      end
    end
    m_stable = ns; m_pp = npp; m_rp = nrp; m_ov = nov;
  endtask

  // Advance one cycle, then drive the inputs held during the next edge.
  task automatic step(input logic [N-1:0] raw_v, input logic ack_v,
                      input logic [N-1:0] mask_v, input logic rst_v);
    @(posedge clk);
    #1;
    cyc++;
    if (reset) model_reset();
    else       model_edge();
    raw_in = raw_v; ack = ack_v; ack_mask = mask_v; reset = rst_v;
    if (rst_v) model_reset();
    exp_q.push_back({m_stable, m_pp, m_rp, m_ov, |(m_pp | m_rp)});
  endtask

  task automatic hold(input logic [N-1:0] raw_v, input int cycles);
    for (int c = 0; c < cycles; c++) step(raw_v, 1'b0, '0, 1'b0);
  endtask

  // Monitor: compare every presented cycle against the oldest prediction.
  initial begin
    logic [4*N:0] e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {stable_level, press_pending, release_pending, overflow, event_valid};
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL outputs cycle=%0d got st=%b pp=%b rp=%b ov=%b ev=%b want st=%b pp=%b rp=%b ov=%b ev=%b",
                   cyc, g[20:16], g[15:11], g[10:6], g[5:1], g[0],
                   e[20:16], e[15:11], e[10:6], e[5:1], e[0]);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] lvl;
    int           left [N];
    int           rst_left;
    logic         a;
    logic [N-1:0] m;

    reset = 1'b1; raw_in = '0; ack = 1'b0; ack_mask = '0;
    model_reset();
    for (int c = 0; c < 3; c++) step('0, 1'b0, '0, 1'b1);
    step('0, 1'b0, '0, 1'b0);
    hold('0, 6);

    // Debounced press on input 0
    hold(5'b00001, 9);
    // Short pulse on input 1 must be filtered
    hold(5'b00011, 3);
    hold(5'b00001, 8);
    // Ack input 0, then release
    step(5'b00001, 1'b1, 5'b00001, 1'b0);
    hold(5'b00001, 2);
    hold(5'b00000, 9);
    step('0, 1'b1, 5'b11111, 1'b0);
    // Two presses on input 2 without ack -> overflow, then masked ack
    hold(5'b00100, 7);
    hold(5'b00000, 7);
    hold(5'b00100, 7);
    step(5'b00100, 1'b1, 5'b00100, 1'b0);
    hold(5'b00100, 2);
    hold(5'b00000, 8);
    step('0, 1'b1, 5'b11111, 1'b0);
    hold('0, 2);
    // Full-mask ack on the very edge input 3 debounces
    step(5'b01000, 1'b0, '0, 1'b0);
    hold(5'b01000, 4);
    step(5'b01000, 1'b1, 5'b11111, 1'b0);
    hold(5'b01000, 3);
    hold(5'b00000, 8);
    step('0, 1'b1, 5'b11111, 1'b0);
    // Reset mid-count on input 4 with the button held
    step(5'b10000, 1'b0, '0, 1'b0);
    hold(5'b10000, 3);
    step(5'b10000, 1'b0, '0, 1'b1);
    step(5'b10000, 1'b0, '0, 1'b1);
    step(5'b10000, 1'b0, '0, 1'b0);
    hold(5'b10000, 8);

    // Randomized phase
    lvl = 5'b10000;
    for (int i = 0; i < N; i++) left[i] = $urandom_range(1, 12);
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        left[i]--;
        if (left[i] <= 0) begin
          lvl[i]  = ~lvl[i];
          left[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 14);
        end
      end
      a = ($urandom_range(0, 5) == 0);
      m = N'($urandom);
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      step(lvl, a, m, rst_left > 0);
    end
    hold('0, 2);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending predictions want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
